rv_alu_datapath: RTL and testbench
==================================

# rv_alu_datapath

Integer execute datapath of the single-cycle RV32I core: decodes one 32-bit instruction per cycle, reads two operands from a 32×32 register file, computes the result in the ALU and writes it back on the next rising clock edge. It covers OP (0x33) and OP-IMM (0x13) instructions and flags SYSTEM (0x73) as a halt request. Fetch, PC sequencing, memory access and the halt register sit in the enclosing core.

## Interface
No parameters; XLEN = 32 and 32 registers are fixed.
- clk  in  1  clock; all state updates on the rising edge
- rst_b  in  1  reset, asynchronous and active-low
- inst  in  32  instruction for this cycle, held stable by the core
- halted  in  1  core halted; blocks all register writes
- dbg_num  in  5  debug register read index
- dbg_data  out  32  contents of register dbg_num (x0 reads 0)
- rs1_num / rs2_num / rd_num  out  5 each  inst[19:15] / inst[24:20] / inst[11:7]
- imm  out  32  inst[31:20], sign-extended
- alu_control  out  4  decoded ALU operation
- alu_result  out  32  ALU output (write-back data)
- rd_we  out  1  effective write enable this cycle
- halt_req  out  1  inst[6:0] == 0x73

## Operation
- ALU codes: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND. Codes 10–15 produce 0.
- OP (0x33), operands rs1_data and rs2_data:
  - funct7 = 0x00: funct3 0–7 → ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - funct7 = 0x20: funct3 0 → SUB, funct3 5 → SRA.
  - Any other funct7/funct3 combination is illegal.
- OP-IMM (0x13), operands rs1_data and imm:
  - funct3 0, 2, 3, 4, 6, 7 → ADD, SLT, SLTU, XOR, OR, AND.
  - funct3 1 requires inst[31:25] = 0 → SLL.
  - funct3 5 with inst[31:25] = 0x00 → SRL; with 0x20 → SRA.
  - Any other shift encoding is illegal.
- Shifts use operand2[4:0] only.
- SLT compares signed and SLTU unsigned; both return 0 or 1.
- ADD and SUB wrap modulo 2^32; no flags.
- Other opcodes, and illegal encodings: alu_control = ADD, both operands forced to 0, alu_result = 0, rd_we = 0.
- rd_we = legal OP or OP-IMM instruction AND !halted AND rd_num ≠ 0.
- Register file:
  - x0 is hardwired to 0; writes to it are discarded.
  - Three combinational read ports: rs1, rs2 and dbg.
  - One synchronous write port; no write-to-read bypass.
- halt_req is purely combinational. It causes no write and does not itself block writes; blocking is done only through the halted input.

## Timing
- Decode, operand selection and ALU are combinational: outputs settle in the same cycle inst is presented.
- Write-back occurs at the rising clk edge when rd_we = 1. The new value is readable by the following instruction, i.e. one cycle of latency.
- A read of the register being written in the same cycle returns the old value.
- Reset (rst_b low) clears all 31 writable registers to 0 immediately, independent of clk, and holds them there while low. No write occurs during reset.
- Reset deasserted mid-operation: the first rising edge after rst_b goes high may write normally.
- Outputs with inst = 0 after reset: rd_we = 0, alu_result = 0, alu_control = 0, halt_req = 0, imm = 0.
- The halted input is sampled on the same edge as the write. If halted = 1 at that edge, no write occurs.

## Structure
- Package rv_alu_pkg holds:
  - opcode constants OPC_OP = 0x33, OPC_OP_IMM = 0x13, OPC_SYSTEM = 0x73;
  - funct7 constants F7_BASE = 0x00, F7_ALT = 0x20;
  - a 4-bit enum alu_op_e with the codes above.
- One sub-module is natural: rv_regfile, holding the 32×32 array, its async reset, the write port and the three read ports.
- Decode and ALU live in the top module as combinational logic.

## Test plan
- Reset, then ADDI x1,x0,-5 (0xFFB00093): alu_result = 0xFFFFFFFB; after the edge, dbg_data(x1) = 0xFFFFFFFB.
- With x1 = 0xFFFFFFFB and x2 = 3, the R-type sequence gives:
  - ADD x3 → 0xFFFFFFFE;
  - SUB x4 → 0xFFFFFFF8;
  - SLT x5 → 1;
  - SLTU x6 → 0;
  - SRA x7 → 0xFFFFFFFF;
  - SRL x8 → 0x1FFFFFFF;
  - SLL x9 → 0xFFFFFFD8.
- ADDI x0,x0,7: rd_we = 0 and x0 stays 0. With halted = 1, ADDI x1,x0,1: x1 is unchanged.
- An illegal R-type with funct7 = 0x01, an illegal SLLI with inst[31:25] = 0x20, and opcode 0x03 each give rd_we = 0, alu_result = 0 and no register change. ECALL 0x00000073 gives halt_req = 1.
- Back-to-back dependency: ADDI x1,x0,1 followed by ADD x1,x1,x1, repeated 4 cycles, gives x1 = 16.
- Pull rst_b low between clk edges after writes: all registers read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// Shared constants and ALU operation codes
// for the RV32I integer execute datapath.
package rv_alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'h33;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

endpackage

// File: rtl/rv_alu_datapath_if.sv
// Signal bundle between the enclosing core
// and the integer execute datapath.
interface rv_alu_datapath_if;

    logic [31:0] inst;
    logic        halted;
    logic [4:0]  dbg_num;
    logic [31:0] dbg_data;
    logic [4:0]  rs1_num;
    logic [4:0]  rs2_num;
    logic [4:0]  rd_num;
    logic [31:0] imm;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        rd_we;
    logic        halt_req;

    modport master (
        output inst, halted, dbg_num,
        input  dbg_data, rs1_num, rs2_num, rd_num,
        input  imm, alu_control, alu_result,
        input  rd_we, halt_req
    );

    modport slave (
        input  inst, halted, dbg_num,
        output dbg_data, rs1_num, rs2_num, rd_num,
        output imm, alu_control, alu_result,
        output rd_we, halt_req
    );

endinterface

// File: rtl/rv_regfile.sv
// 32x32 register file: x0 fixed at zero, one write
// port, three combinational read ports, async reset.
module rv_regfile (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  ra3,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [31:0] rd3
);

    logic [31:0] regs [32];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // No bypass: a same-cycle read sees the old value.
    assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
    assign rd3 = (ra3 == 5'd0) ? '0 : regs[ra3];

endmodule

// File: rtl/rv_alu_datapath.sv
// Single-cycle RV32I OP / OP-IMM decode, operand
// select, ALU and register write-back.
module rv_alu_datapath
    import rv_alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_b,
    rv_alu_datapath_if.slave     bus
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        legal;
    alu_op_e     op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [4:0]  shamt;
    logic [31:0] res;

    assign opcode = bus.inst[6:0];
    assign funct3 = bus.inst[14:12];
    assign funct7 = bus.inst[31:25];

    assign bus.rs1_num  = bus.inst[19:15];
    assign bus.rs2_num  = bus.inst[24:20];
    assign bus.rd_num   = bus.inst[11:7];
    assign bus.imm      = {{20{bus.inst[31]}}, bus.inst[31:20]};
    assign bus.halt_req = (opcode == OPC_SYSTEM);

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        unique case (1'b1)
            (opcode == OPC_OP): begin
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                    case (funct3)
                        3'd0:    op = ALU_ADD;
                        3'd1:    op = ALU_SLL;
                        3'd2:    op = ALU_SLT;
                        3'd3:    op = ALU_SLTU;
                        3'd4:    op = ALU_XOR;
                        3'd5:    op = ALU_SRL;
                        3'd6:    op = ALU_OR;
                        default: op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'd0) begin
                        legal = 1'b1;
                        op    = ALU_SUB;
                    end else if (funct3 == 3'd5) begin
                        legal = 1'b1;
                        op    = ALU_SRA;
                    end
                end
            end
            (opcode == OPC_OP_IMM): begin
                legal = 1'b1;
                case (funct3)
                    3'd0: op = ALU_ADD;
                    3'd1: begin
                        op    = ALU_SLL;
                        legal = (funct7 == F7_BASE);
                    end
                    3'd2: op = ALU_SLT;
                    3'd3: op = ALU_SLTU;
                    3'd4: op = ALU_XOR;
                    3'd5: begin
                        op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'd6: op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            default: legal = 1'b0;
        endcase
        // Anything not executed looks like ADD of zeros.
        if (!legal) begin
            op = ALU_ADD;
        end
    end

    assign opa   = legal ? rs1_data : '0;
    assign opb   = !legal ? '0 :
                   (opcode == OPC_OP) ? rs2_data : bus.imm;
    assign shamt = opb[4:0];

    always_comb begin
        res = '0;
        case (op)
            ALU_ADD:  res = opa + opb;
            ALU_SUB:  res = opa - opb;
            ALU_SLL:  res = opa << shamt;
            ALU_SLT:  res = {31'd0, $signed(opa) < $signed(opb)};
            ALU_SLTU: res = {31'd0, opa < opb};
            ALU_XOR:  res = opa ^ opb;
            ALU_SRL:  res = opa >> shamt;
            ALU_SRA:  res = $unsigned($signed(opa) >>> shamt);
            ALU_OR:   res = opa | opb;
            ALU_AND:  res = opa & opb;
            default:  res = '0;
        endcase
    end

    assign bus.alu_control = op;
    assign bus.alu_result  = res;
    assign bus.rd_we       = legal && !bus.halted
                             && (bus.rd_num != 5'd0);

    rv_regfile u_regfile (
        .clk   (clk),
        .rst_b (rst_b),
        .we    (bus.rd_we),
        .waddr (bus.rd_num),
        .wdata (res),
        .ra1   (bus.rs1_num),
        .ra2   (bus.rs2_num),
        .ra3   (bus.dbg_num),
        .rd1   (rs1_data),
        .rd2   (rs2_data),
        .rd3   (bus.dbg_data)
    );

endmodule

// File: tb/tb_rv_alu_datapath.sv
// Directed-vector bench for rv_alu_datapath with
// hand-computed expected values.
module tb_rv_alu_datapath;

    logic clk;
    logic rst_b;
    int   vecs;
    int   errs;

    rv_alu_datapath_if bus ();

    rv_alu_datapath dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] im,
        input logic [4:0] rs1, input logic [2:0] f3,
        input logic [4:0] rd, input logic [6:0] opc);
        return {im, rs1, f3, rd, opc};
    endfunction

    task automatic apply(input logic [31:0] i);
        @(negedge clk);
        bus.inst = i;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd_reg(input logic [4:0] n, output logic [31:0] v);
        bus.dbg_num = n;
        #1;
        v = bus.dbg_data;
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] n,
                           input logic [31:0] exp);
        logic [31:0] v;
        rd_reg(n, v);
        check(tag, v, exp);
    endtask

    task automatic run_r(input string tag, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] exp);
        apply(rtype(f7, 5'd2, 5'd1, f3, rd));
        check({tag, "_res"}, bus.alu_result, exp);
        check({tag, "_we"}, {31'd0, bus.rd_we}, 32'd1);
        tick();
        chk_reg({tag, "_wb"}, rd, exp);
    endtask

    task automatic run_bad(input string tag, input logic [31:0] i,
                           input logic [4:0] rd);
        apply(i);
        check({tag, "_we"}, {31'd0, bus.rd_we}, 32'd0);
        check({tag, "_res"}, bus.alu_result, 32'd0);
        check({tag, "_ctl"}, {28'd0, bus.alu_control}, 32'd0);
        tick();
        chk_reg({tag, "_reg"}, rd, 32'd0);
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        bus.inst = '0;
        bus.halted = 1'b0;
        bus.dbg_num = '0;
        rst_b = 1'b0;
        #12;
        check("rst_we", {31'd0, bus.rd_we}, 32'd0);
        check("rst_res", bus.alu_result, 32'd0);
        check("rst_ctl", {28'd0, bus.alu_control}, 32'd0);
        check("rst_halt", {31'd0, bus.halt_req}, 32'd0);
        check("rst_imm", bus.imm, 32'd0);
        rst_b = 1'b1;

        // ADDI x1,x0,-5 and ADDI x2,x0,3
        apply(32'hFFB00093);
        check("addi_res", bus.alu_result, 32'hFFFFFFFB);
        check("addi_imm", bus.imm, 32'hFFFFFFFB);
        tick();
        chk_reg("addi_x1", 5'd1, 32'hFFFFFFFB);
        apply(32'h00300113);
        tick();
        chk_reg("addi_x2", 5'd2, 32'd3);

        run_r("add",  7'h00, 3'd0, 5'd3, 32'hFFFFFFFE);
        run_r("sub",  7'h20, 3'd0, 5'd4, 32'hFFFFFFF8);
        run_r("slt",  7'h00, 3'd2, 5'd5, 32'd1);
        run_r("sltu", 7'h00, 3'd3, 5'd6, 32'd0);
        run_r("sra",  7'h20, 3'd5, 5'd7, 32'hFFFFFFFF);
        run_r("srl",  7'h00, 3'd5, 5'd8, 32'h1FFFFFFF);
        run_r("sll",  7'h00, 3'd1, 5'd9, 32'hFFFFFFD8);
        run_r("xor",  7'h00, 3'd4, 5'd13, 32'hFFFFFFF8);
        run_r("or",   7'h00, 3'd6, 5'd14, 32'hFFFFFFFB);
        run_r("and",  7'h00, 3'd7, 5'd15, 32'd3);

        // SRAI x16,x1,1 and SLTIU x17,x1,-1
        apply(itype({7'h20, 5'd1}, 5'd1, 3'd5, 5'd16, 7'h13));
        check("srai_res", bus.alu_result, 32'hFFFFFFFD);
        check("srai_ctl", {28'd0, bus.alu_control}, 32'd7);
        apply(itype(12'hFFF, 5'd1, 3'd3, 5'd17, 7'h13));
        check("sltiu_res", bus.alu_result, 32'd1);

        // ADDI x0,x0,7
        apply(32'h00700013);
        check("x0_we", {31'd0, bus.rd_we}, 32'd0);
        tick();
        chk_reg("x0_val", 5'd0, 32'd0);

        // Halted blocks ADDI x1,x0,1
        bus.halted = 1'b1;
        apply(32'h00100093);
        check("hlt_we", {31'd0, bus.rd_we}, 32'd0);
        tick();
        chk_reg("hlt_x1", 5'd1, 32'hFFFFFFFB);
        bus.halted = 1'b0;

        run_bad("bad_f7", rtype(7'h01, 5'd2, 5'd1, 3'd0, 5'd10), 5'd10);
        run_bad("bad_slli",
                itype({7'h20, 5'd3}, 5'd1, 3'd1, 5'd11, 7'h13), 5'd11);
        run_bad("bad_opc", itype(12'd4, 5'd1, 3'd2, 5'd12, 7'h03), 5'd12);

        apply(32'h00000073);
        check("ecall_hr", {31'd0, bus.halt_req}, 32'd1);
        check("ecall_we", {31'd0, bus.rd_we}, 32'd0);

        // Same-cycle read of rd sees old value, then dependency chain
        apply(32'h00100093);
        tick();
        for (int k = 0; k < 4; k++) begin
            apply(rtype(7'h00, 5'd1, 5'd1, 3'd0, 5'd1));
            tick();
        end
        chk_reg("dep_x1", 5'd1, 32'd16);

        // Async reset between edges
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        chk_reg("arst_x1", 5'd1, 32'd0);
        chk_reg("arst_x3", 5'd3, 32'd0);
        chk_reg("arst_x9", 5'd9, 32'd0);
        #5;
        rst_b = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
